// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready stream interface.
// Define PREFIX_ADDER_PIPE_FLAGS_EN to add registered zero/neg result flags.
module prefix_adder_pipe #(
  parameter int WIDTH     = 16,
  parameter int REG_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef PREFIX_ADDER_PIPE_FLAGS_EN
  output logic             ovf,
  output logic             zero,
  output logic             neg
`else
  output logic             ovf
`endif
);

  localparam int LOG2W   = $clog2(WIDTH);
  localparam int NGROUPS = (LOG2W + REG_EVERY - 1) / REG_EVERY;
  localparam int SW      = WIDTH + 4;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic [WIDTH-1:0] opX, opY;
  logic             opC0, opV;

  // Operand register: subtraction is folded in here as x + ~y + 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      opX  <= '0;
      opY  <= '0;
      opC0 <= 1'b0;
      opV  <= 1'b0;
    end else if (en) begin
      opX  <= x;
      opY  <= sub ? ~y : y;
      opC0 <= sub | cin;
      opV  <= in_valid;
    end
  end

  logic [WIDTH-1:0] g0, p0;

  always_comb begin
    p0    = opX ^ opY;
    g0    = opX & opY;
    g0[0] = (opX[0] & opY[0]) | (opC0 & (opX[0] | opY[0]));
  end

  // Side channel travelling with each beat: {valid, xMsb, yMsb, c0, p0}.
  logic [SW-1:0] opSide;
  assign opSide = {opV, opX[WIDTH-1], opY[WIDTH-1], opC0, p0};

  for (genvar k = 0; k < LOG2W; k++) begin : lvl
    localparam int D = 1 << k;
    localparam logic [WIDTH-1:0] LOWMASK = {WIDTH{1'b1}} >> (WIDTH - D);
    logic [WIDTH-1:0] gIn, pIn, gOut;

    if (k == 0) begin : fromOp
      assign gIn = g0;
      assign pIn = p0;
    end else if (k % REG_EVERY == 0) begin : fromBank
      assign gIn = bank[k / REG_EVERY].g;
      assign pIn = bank[k / REG_EVERY].p;
    end else begin : fromLvl
      assign gIn = lvl[k-1].gOut;
      assign pIn = lvl[k-1].pNext.pOut;
    end

    // Bits below the span distance have no partner and pass through.
    assign gOut = gIn | (pIn & (gIn << D));

    if (k < LOG2W - 1) begin : pNext
      logic [WIDTH-1:0] pOut;
      assign pOut = pIn & ((pIn << D) | LOWMASK);
    end
  end

  for (genvar b = 1; b < NGROUPS; b++) begin : bank
    logic [WIDTH-1:0] g, p, gD, pD;
    logic [SW-1:0]    side, sideD;

    assign gD = lvl[b*REG_EVERY-1].gOut;
    assign pD = lvl[b*REG_EVERY-1].pNext.pOut;

    if (b == 1) begin : sideFromOp
      assign sideD = opSide;
    end else begin : sideFromBank
      assign sideD = bank[b-1].side;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        g    <= '0;
        p    <= '0;
        side <= '0;
      end else if (en) begin
        g    <= gD;
        p    <= pD;
        side <= sideD;
      end
    end
  end

  logic [SW-1:0]    lastSide;
  logic [WIDTH-1:0] gFinal, sumNext;

  if (NGROUPS == 1) begin : sideDirect
    assign lastSide = opSide;
  end else begin : sideBanked
    assign lastSide = bank[NGROUPS-1].side;
  end

  assign gFinal  = lvl[LOG2W-1].gOut;
  assign sumNext = lastSide[WIDTH-1:0] ^ {gFinal[WIDTH-2:0], lastSide[WIDTH]};

  // Output register; the final prefix group always terminates here.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (en) begin
      out_valid <= lastSide[SW-1];
      sum       <= sumNext;
      cout      <= gFinal[WIDTH-1];
      ovf       <= (lastSide[SW-2] == lastSide[SW-3]) && (sumNext[WIDTH-1] != lastSide[SW-2]);
    end
  end

`ifdef PREFIX_ADDER_PIPE_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      zero <= 1'b0;
      neg  <= 1'b0;
    end else if (en) begin
      zero <= (sumNext == '0);
      neg  <= sumNext[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Self-checking bench for prefix_adder_pipe: arithmetic reference model with a
// result queue, directed corner cases, backpressure and mid-stream reset.
module tb_prefix_adder_pipe;

  localparam int W       = 16;
  localparam int R       = 2;
  localparam int LATENCY = 1 + ($clog2(W) + R - 1) / R;

  logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, cin = 1'b0, sub = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid, cout, ovf;
  logic [W-1:0] x = '0, y = '0, sum;
`ifdef PREFIX_ADDER_PIPE_FLAGS_EN
  logic         zero, neg;
`endif

  int checks = 0, errors = 0, popCount = 0;
  logic [W+3:0] expQ[$];
  logic         holdPend = 1'b0, rstSeen = 1'b0, stopRdy = 1'b0;
  logic [W-1:0] heldSum;
  logic         heldCout, heldOvf;

  prefix_adder_pipe #(.WIDTH(W), .REG_EVERY(R)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout),
`ifdef PREFIX_ADDER_PIPE_FLAGS_EN
    .ovf(ovf), .zero(zero), .neg(neg)
`else
    .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: returns {neg, zero, ovf, cout, sum} from integer arithmetic.
  function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci, input logic s);
    int unsigned ua, ub, full;
    int          sa, sb, sres;
    logic [W-1:0] r;
    logic        co, ov;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    if (s) begin
      full = ua - ub;
      co   = (ua >= ub);
      sres = sa - sb;
    end else begin
      full = ua + ub + int'(ci);
      co   = (full >= (1 << W));
      sres = sa + sb + int'(ci);
    end
    r  = full[W-1:0];
    ov = (sres > (2 ** (W - 1)) - 1) || (sres < -(2 ** (W - 1)));
    return {r[W-1], (r == '0), ov, co, r};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Must be called shortly after a rising edge; returns 1ns after the accepting edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic ci, input logic s);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    x = a; y = b; cin = ci; sub = s; in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready && !rst;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL acceptTimeout: got no accept expected accept within 50 cycles");
    end
  endtask

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic s, input logic [W-1:0] eSum, input logic eCout,
                          input logic eOvf, input logic eZero, input logic eNeg);
    int n;
    applyStimulus(a, b, ci, s);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("latency", n, LATENCY);
    checkOutput("litSum", sum, eSum);
    checkOutput("litCout", cout, eCout);
    checkOutput("litOvf", ovf, eOvf);
`ifdef PREFIX_ADDER_PIPE_FLAGS_EN
    checkOutput("litZero", zero, eZero);
    checkOutput("litNeg", neg, eNeg);
`else
    if (eZero && eNeg) $display("[TB] note: zero and neg both expected on a flagless build");
`endif
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drained", expQ.size(), 0);
  endtask

  // Mid-cycle monitor: records accepts into the model queue and checks every handshake.
  always @(negedge clk) begin
    logic [W+3:0] e;
    if (rst) begin
      expQ.delete();
      holdPend = 1'b0;
      rstSeen  = 1'b1;
    end else begin
      if (rstSeen) begin
        checkOutput("validAfterReset", out_valid, 0);
        rstSeen = 1'b0;
      end
      checkOutput("inReady", in_ready, !out_valid || out_ready);
      if (holdPend) begin
        checkOutput("holdValid", out_valid, 1);
        checkOutput("holdSum", sum, heldSum);
        checkOutput("holdCout", cout, heldCout);
        checkOutput("holdOvf", ovf, heldOvf);
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedBeat: got sum %0h expected no beat", sum);
        end else begin
          e = expQ.pop_front();
          popCount++;
          checkOutput("sum", sum, e[W-1:0]);
          checkOutput("cout", cout, e[W]);
          checkOutput("ovf", ovf, e[W+1]);
`ifdef PREFIX_ADDER_PIPE_FLAGS_EN
          checkOutput("zero", zero, e[W+2]);
          checkOutput("neg", neg, e[W+3]);
`endif
        end
      end
      holdPend = out_valid && !out_ready;
      heldSum  = sum;
      heldCout = cout;
      heldOvf  = ovf;
      if (in_valid && in_ready) expQ.push_back(model(x, y, cin, sub));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int base;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("resetValid", out_valid, 0);
    checkOutput("resetSum", sum, 0);
    checkOutput("resetCout", cout, 0);
    checkOutput("resetOvf", ovf, 0);
    checkOutput("resetInReady", in_ready, 1);
    @(posedge clk);
    #1;

    directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    directed(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    directed(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    directed(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    waitDrain();

    base = popCount;
    fork
      for (int i = 0; i < 8; i++) applyStimulus(W'(i), W'(16'h0100 * i), 1'b0, 1'b0);
      for (int c = 0; c < 10; c++) begin
        @(posedge clk);
        #1;
        out_ready = !(c >= 3 && c <= 6);
      end
    join
    out_ready = 1'b1;
    waitDrain();
    checkOutput("streamCount", popCount - base, 8);

    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0);
    applyStimulus(16'h2222, 16'h0001, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("staleValid", out_valid, 0);
    end
    directed(16'hABCD, 16'h1234, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0, 1'b1);
    waitDrain();

    stopRdy = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        stopRdy = 1'b1;
      end
      while (!stopRdy) begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    out_ready = 1'b1;
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
